// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Program counter with increment, absolute/relative branch, and a small
// return-address stack for CALL/RET. PC and stack advance only on cycles
// qualified by SLOW_CLOCK_STRB.
//
// Ports
//   CLK             : system clock, all state on posedge
//   ACLR            : asynchronous active-high reset
//   SLOW_CLOCK_STRB : one-CLK enable; PC/stack change only when 1
//   PC_COUNT        : increment request
//   BRANCH          : jump request (BRANCH_REL: 1 = relative, 0 = absolute)
//   CALL            : push PC+1, jump absolute to BRANCH_ADDRESS
//   RET             : pop top of stack into PC
//   BRANCH_ADDRESS  : absolute target or two's-complement offset
//   PC_VAL          : internal PC delayed by one CLK
//   STACK_LEVEL     : number of entries currently on the stack
//   STACK_ERR       : sticky overflow/underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module program_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_VEC   = 0,
    localparam int unsigned LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              ACLR,
    input  logic              SLOW_CLOCK_STRB,
    input  logic              PC_COUNT,
    input  logic              BRANCH,
    input  logic              BRANCH_REL,
    input  logic              CALL,
    input  logic              RET,
    input  logic [ADDR_W-1:0] BRANCH_ADDRESS,
    output logic [ADDR_W-1:0] PC_VAL,
    output logic [LVL_W-1:0]  STACK_LEVEL,
    output logic              STACK_ERR
);

    localparam int unsigned IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned MEM_DEPTH = 1 << IDX_W;
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_val_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q, err_d;

    // Stack storage is not reset: discarding on reset only needs level_q = 0.
    logic [ADDR_W-1:0] stack_q [MEM_DEPTH];

    logic              push_en;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign push_idx = IDX_W'(level_q);
    assign pop_idx  = IDX_W'(level_q - LVL_W'(1));

    // Next-state: priority RET > CALL > BRANCH > PC_COUNT, strobe-qualified.
    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (SLOW_CLOCK_STRB) begin
            if (RET) begin
                if (level_q != '0) begin
                    pc_d    = stack_q[pop_idx];
                    level_d = level_q - LVL_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (CALL) begin
                if (level_q < LVL_W'(STACK_DEPTH)) begin
                    push_en = 1'b1;
                    pc_d    = BRANCH_ADDRESS;
                    level_d = level_q + LVL_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (BRANCH) begin
                // Same-width add wraps modulo 2^ADDR_W, which matches a
                // sign-extended offset.
                pc_d = BRANCH_REL ? (pc_q + BRANCH_ADDRESS) : BRANCH_ADDRESS;
            end else if (PC_COUNT) begin
                pc_d = pc_inc;
            end
        end
    end

    // Sequencer state and the one-cycle PC copy.
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            pc_q     <= RST_PC;
            pc_val_q <= RST_PC;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_val_q <= pc_q;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    // Return-address storage.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign PC_VAL      = pc_val_q;
    assign STACK_LEVEL = level_q;
    assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Directed bench for program_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0).
// Inputs change on negedge; outputs are checked on negedge.
// -----------------------------------------------------------------------------
module tb_program_sequencer;

    logic       CLK = 1'b0;
    logic       ACLR;
    logic       SLOW_CLOCK_STRB;
    logic       PC_COUNT;
    logic       BRANCH;
    logic       BRANCH_REL;
    logic       CALL;
    logic       RET;
    logic [7:0] BRANCH_ADDRESS;
    logic [7:0] PC_VAL;
    logic [2:0] STACK_LEVEL;
    logic       STACK_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    program_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_VEC   (0)
    ) dut (
        .CLK             (CLK),
        .ACLR            (ACLR),
        .SLOW_CLOCK_STRB (SLOW_CLOCK_STRB),
        .PC_COUNT        (PC_COUNT),
        .BRANCH          (BRANCH),
        .BRANCH_REL      (BRANCH_REL),
        .CALL            (CALL),
        .RET             (RET),
        .BRANCH_ADDRESS  (BRANCH_ADDRESS),
        .PC_VAL          (PC_VAL),
        .STACK_LEVEL     (STACK_LEVEL),
        .STACK_ERR       (STACK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        SLOW_CLOCK_STRB = 1'b0;
        PC_COUNT        = 1'b0;
        BRANCH          = 1'b0;
        BRANCH_REL      = 1'b0;
        CALL            = 1'b0;
        RET             = 1'b0;
        BRANCH_ADDRESS  = 8'h00;
    endtask

    // One strobed operation; returns at the negedge where PC_VAL shows the result.
    task automatic op(input logic cnt, input logic br, input logic rel,
                      input logic cl, input logic rt, input logic [7:0] addr);
        SLOW_CLOCK_STRB = 1'b1;
        PC_COUNT        = cnt;
        BRANCH          = br;
        BRANCH_REL      = rel;
        CALL            = cl;
        RET             = rt;
        BRANCH_ADDRESS  = addr;
        @(negedge CLK);
        clear_inputs();
        @(negedge CLK);
    endtask

    task automatic expect_state(input string tag, input logic [7:0] pc,
                                input logic [2:0] lvl, input logic err);
        check({tag, ".pc"},  16'(PC_VAL),      16'(pc));
        check({tag, ".lvl"}, 16'(STACK_LEVEL), 16'(lvl));
        check({tag, ".err"}, 16'(STACK_ERR),   16'(err));
    endtask

    initial begin
        clear_inputs();
        ACLR = 1'b1;
        #2;
        // Reset values visible before any clock edge.
        expect_state("reset", 8'h00, 3'd0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        ACLR = 1'b0;
        @(negedge CLK);
        expect_state("post_rst", 8'h00, 3'd0, 1'b0);

        // Increment: PC_VAL lags the strobe by one CLK.
        SLOW_CLOCK_STRB = 1'b1;
        PC_COUNT        = 1'b1;
        @(negedge CLK);
        clear_inputs();
        check("inc1_lag", 16'(PC_VAL), 16'h0000);
        @(negedge CLK);
        check("inc1", 16'(PC_VAL), 16'h0001);
        op(1, 0, 0, 0, 0, 8'h00);
        check("inc2", 16'(PC_VAL), 16'h0002);
        op(1, 0, 0, 0, 0, 8'h00);
        check("inc3", 16'(PC_VAL), 16'h0003);

        // Requests without strobe are ignored.
        PC_COUNT = 1'b1;
        BRANCH   = 1'b1;
        CALL     = 1'b1;
        BRANCH_ADDRESS = 8'h77;
        repeat (3) @(negedge CLK);
        clear_inputs();
        @(negedge CLK);
        expect_state("no_strb", 8'h03, 3'd0, 1'b0);

        // Strobe with no request holds.
        op(0, 0, 0, 0, 0, 8'h55);
        check("idle_strb", 16'(PC_VAL), 16'h0003);

        // Wrap-around.
        op(0, 1, 0, 0, 0, 8'hFE);
        check("br_fe", 16'(PC_VAL), 16'h00FE);
        op(1, 0, 0, 0, 0, 8'h00);
        check("wrap_ff", 16'(PC_VAL), 16'h00FF);
        op(1, 0, 0, 0, 0, 8'h00);
        expect_state("wrap_00", 8'h00, 3'd0, 1'b0);

        // Relative / absolute branch, branch beats count.
        op(0, 1, 0, 0, 0, 8'h10);
        check("br_10", 16'(PC_VAL), 16'h0010);
        op(0, 1, 1, 0, 0, 8'hFC);
        check("br_rel", 16'(PC_VAL), 16'h000C);
        op(1, 1, 0, 0, 0, 8'h40);
        check("br_prio", 16'(PC_VAL), 16'h0040);

        // Call/return nesting; CALL ignores BRANCH_REL; RET beats CALL.
        op(0, 1, 0, 0, 0, 8'h05);
        check("br_05", 16'(PC_VAL), 16'h0005);
        op(1, 1, 1, 1, 0, 8'h80);
        expect_state("call1", 8'h80, 3'd1, 1'b0);
        op(0, 0, 0, 1, 0, 8'h90);
        expect_state("call2", 8'h90, 3'd2, 1'b0);
        op(0, 0, 0, 1, 1, 8'hA0);
        expect_state("ret1", 8'h81, 3'd1, 1'b0);
        op(0, 0, 0, 0, 1, 8'h00);
        expect_state("ret2", 8'h06, 3'd0, 1'b0);

        // Overflow at depth 4.
        op(0, 0, 0, 1, 0, 8'h20);
        op(0, 0, 0, 1, 0, 8'h30);
        op(0, 0, 0, 1, 0, 8'h40);
        op(0, 0, 0, 1, 0, 8'h50);
        expect_state("call4", 8'h50, 3'd4, 1'b0);
        op(0, 0, 0, 1, 0, 8'h60);
        expect_state("ovf", 8'h50, 3'd4, 1'b1);
        op(1, 0, 0, 0, 0, 8'h00);
        expect_state("ovf_cnt", 8'h51, 3'd4, 1'b1);
        op(0, 0, 0, 0, 1, 8'h00);
        expect_state("ovf_ret", 8'h41, 3'd3, 1'b1);

        // Asynchronous reset pulse between edges mid call sequence.
        op(0, 0, 0, 1, 0, 8'h70);
        expect_state("pre_aclr", 8'h70, 3'd4, 1'b1);
        #2 ACLR = 1'b1;
        #1;
        expect_state("aclr", 8'h00, 3'd0, 1'b0);
        #1 ACLR = 1'b0;
        @(negedge CLK);
        expect_state("aclr_rel", 8'h00, 3'd0, 1'b0);

        // Underflow: stack discarded by reset.
        op(0, 0, 0, 0, 1, 8'h00);
        expect_state("udf", 8'h00, 3'd0, 1'b1);
        op(1, 0, 0, 0, 0, 8'h00);
        expect_state("udf_cnt", 8'h01, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of program address, PC and stack entries (legal 4..16).
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address stack entries (legal 1..16).
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 CLK  in  1: single system clock; all state updates on posedge CLK.
REQ-005 ACLR  in  1: reset, asynchronous, active-high; asserts immediately, releases synchronously to CLK externally.
REQ-006 SLOW_CLOCK_STRB  in  1: one-CLK enable pulse; PC and stack change only in cycles where it is 1.
REQ-007 PC_COUNT  in  1: increment request.
REQ-008 BRANCH  in  1: jump request.
REQ-009 BRANCH_REL  in  1: qualifies BRANCH; 1 = relative, 0 = absolute.
REQ-010 CALL  in  1: subroutine call request.
REQ-011 RET  in  1: subroutine return request.
REQ-012 BRANCH_ADDRESS  in  ADDR_W: absolute target, or two's-complement offset when BRANCH_REL=1.
REQ-013 PC_VAL  out  ADDR_W: registered copy of internal PC.
REQ-014 STACK_LEVEL  out  clog2(STACK_DEPTH+1): current number of stacked entries.
REQ-015 STACK_ERR  out  1: sticky overflow/underflow flag.

Function
REQ-016 Internal PC register pc_i SHALL update only on a posedge CLK where SLOW_CLOCK_STRB=1; with SLOW_CLOCK_STRB=0 pc_i, stack and STACK_LEVEL hold.
REQ-017 Request priority within one strobe cycle SHALL be RET > CALL > BRANCH > PC_COUNT; lower-priority requests in the same cycle are ignored.
REQ-018 PC_COUNT: pc_i <= pc_i + 1 modulo 2^ADDR_W (all-ones wraps to 0, no flag).
REQ-019 BRANCH, BRANCH_REL=0: pc_i <= BRANCH_ADDRESS.
REQ-020 BRANCH, BRANCH_REL=1: pc_i <= pc_i + sign-extended BRANCH_ADDRESS, modulo 2^ADDR_W.
REQ-021 CALL, STACK_LEVEL < STACK_DEPTH: push pc_i+1 (mod 2^ADDR_W), STACK_LEVEL += 1, pc_i <= BRANCH_ADDRESS (always absolute; BRANCH_REL ignored).
REQ-022 CALL, STACK_LEVEL = STACK_DEPTH: no push, pc_i unchanged, STACK_ERR <= 1.
REQ-023 RET, STACK_LEVEL > 0: pc_i <= top entry, STACK_LEVEL -= 1 (LIFO).
REQ-024 RET, STACK_LEVEL = 0: pc_i unchanged, STACK_ERR <= 1.
REQ-025 STACK_ERR SHALL remain 1 until reset; it does not block further operations.
REQ-026 PC_VAL SHALL equal pc_i delayed by exactly one CLK (updated every CLK regardless of strobe).
REQ-027 STACK_LEVEL SHALL be registered and reflect the stack state in the same cycle as pc_i.
REQ-028 No request in a strobe cycle: all state holds.

Reset
REQ-029 While ACLR=1, pc_i and PC_VAL SHALL be RESET_VEC, STACK_LEVEL 0, STACK_ERR 0, independent of CLK.
REQ-030 ACLR asserted mid-sequence (e.g. between CALL and RET) SHALL discard stack contents; stack entries need not be cleared, only STACK_LEVEL.
REQ-031 First update after release SHALL occur on the first posedge CLK with SLOW_CLOCK_STRB=1 and ACLR=0.

Verification
REQ-032 Reset, then 3 strobes with PC_COUNT=1 -> PC_VAL 0,1,2,3 each one CLK after strobe; PC_COUNT held without strobe -> no change.
REQ-033 pc_i=0xFE, two PC_COUNT strobes -> 0xFF then 0x00, STACK_ERR=0.
REQ-034 pc_i=0x10, BRANCH=1, BRANCH_REL=1, BRANCH_ADDRESS=0xFC -> 0x0C; BRANCH_REL=0, BRANCH_ADDRESS=0x40 -> 0x40; BRANCH+PC_COUNT same strobe -> branch wins.
REQ-035 pc_i=0x05, CALL to 0x80 -> pc 0x80, STACK_LEVEL 1; CALL to 0x90 -> STACK_LEVEL 2; RET -> 0x81; RET -> 0x06, STACK_LEVEL 0.
REQ-036 STACK_DEPTH=4: 5 CALLs -> 5th leaves pc unchanged, STACK_ERR=1, STACK_LEVEL 4; reset -> RET at level 0 leaves pc unchanged, STACK_ERR=1.
REQ-037 ACLR pulsed between clock edges during CALL sequence -> PC_VAL=RESET_VEC, STACK_LEVEL=0 immediately, STACK_ERR=0.
